seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//  Multi-cycle shift-add multiplier feeding the HI/LO register in EX stage of 5-stage CPU.
//  Accepts MULT/MULTU/MADD/MADDU from ID/EX; drives 64-bit product plus HI/LO write command (load/accumulate).
//  Asserts busy so hazard unit stalls issue of a new mul op and MFHI/MFLO until result is written.
// PARAMETERS
//  WIDTH   32   operand width; product is 2*WIDTH bits
// PORTS
//  clk       in   1        rising-edge clock
//  reset     in   1        asynchronous, active-high; clears all state
//  start     in   1        request new multiply (sampled only in IDLE)
//  op        in   2        mul_pkg::MUL_LOAD=2'b01 (MULT/MULTU), MUL_ACC=2'b10 (MADD/MADDU); 00/11 -> start ignored
//  is_signed in   1        1: two's-complement operands; 0: unsigned
//  flush     in   1        pipeline flush: abort in-flight op, no HI/LO write
//  src_a     in   WIDTH    multiplicand (rs)
//  src_b     in   WIDTH    multiplier (rt)
//  busy      out  1        state != IDLE
//  mul_ans   out  2*WIDTH  product to HI/LO; valid only while mul != 0
//  mul       out  2        HI/LO command: 00 none, 01 load, 10 accumulate; one-cycle pulse
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, mul=00, mul_ans=0, internal regs=0; reset mid-op drops op, no HI/LO write.
//  FSM IDLE -> CALC -> DONE -> IDLE.
//   IDLE: start && op in {01,10} && !flush: latch op, sign_res = is_signed & (a[W-1]^b[W-1]);
//         mcand=|a|, mplier=|b| if is_signed else raw; acc=0; count=WIDTH; -> CALC.
//   CALC: per cycle: if mplier[0] acc_hi += mcand (WIDTH+1-bit add, carry kept);
//         {acc, mplier} shift right 1; count--; count reaches 0 -> DONE.
//   DONE: mul_ans = sign_res ? -prod : prod (2*WIDTH wrap); mul = latched op for this cycle only; -> IDLE.
//  Latency: start sampled at edge N -> mul valid in cycle N+WIDTH+1 (33 for WIDTH=32); busy high N+1..N+WIDTH+1.
//  start while busy: ignored (hazard unit holds instruction); start and flush same cycle: flush wins.
//  flush in CALC: -> IDLE next edge, mul stays 00. flush in DONE: command suppressed (mul=00).
//  |-2^(W-1)| taken as unsigned 2^(W-1) (no overflow); result -2^(W-1)*-2^(W-1)=2^(2W-2).
//  mul is 00 in all states except DONE; mul_ans held 0 outside DONE.
// CONFIGURATION
//  SEQ_MUL_EARLY_TERM_EN defined: in CALC, if remaining mplier bits all zero, skip to DONE next edge
//   (acc shifted right by remaining count in one step); latency = 2 + index of highest set bit of |b|, min 2.
//   b=0 -> DONE one cycle after start.
//  Not defined: fixed WIDTH-cycle CALC regardless of operand values.
// STRUCTURE
//  mul_pkg: MUL_NONE/MUL_LOAD/MUL_ACC 2-bit constants (shared with HI/LO and control unit), state encodings
//   S_IDLE/S_CALC/S_DONE, WIDTH default.
//  One sub-module: mul_abs_conv (WIDTH-bit conditional negate) used for operand abs and result sign fix.
//  FSM, counter and datapath in top module.
// TESTING
//  1) MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> 33 cycles later mul=01, mul_ans=0xFFFFFFFE_00000001, one-cycle pulse.
//  2) MULT signed a=0xFFFFFFFE(-2) b=3 -> mul_ans=0xFFFFFFFF_FFFFFFFA; a=b=0x80000000 -> 0x40000000_00000000.
//  3) MADD a=5 b=7 -> mul=10, mul_ans=35; with HI/LO holding 100, HI/LO reads 135 after write.
//  4) start mid-CALC with new operands -> ignored, first result unchanged; busy continuously high until DONE.
//  5) flush at cycle 10 of CALC -> busy low next cycle, mul never non-zero; reset at cycle 5 -> all outputs 0.
//  6) SEQ_MUL_EARLY_TERM_EN: a=9 b=1 -> result 9 in 2 cycles; b=0 -> 0 in 2; without macro both take 33.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants for the EX-stage sequential multiplier and the HI/LO unit.
// HI/LO command encodings, FSM states and default operand width.
package mul_pkg;

  localparam int MUL_WIDTH = 32;

  localparam logic [1:0] MUL_NONE = 2'b00;
  localparam logic [1:0] MUL_LOAD = 2'b01;
  localparam logic [1:0] MUL_ACC  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mul_abs_conv.sv
// Conditional two's-complement negate.
// Used for operand magnitude and for the result sign fix.
module mul_abs_conv #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/seq_multiplier.sv
// Shift-add multiplier driving HI/LO load/accumulate commands.
// Optional SEQ_MUL_EARLY_TERM_EN: finish once remaining multiplier bits are zero.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic               is_signed,
  input  logic               flush,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               busy,
  output logic [2*WIDTH-1:0] mul_ans,
  output logic [1:0]         mul
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e             state_q;
  logic [1:0]         op_q;
  logic [1:0]         mul_q;
  logic               sign_q;
  logic               busy_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      count_q;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] prod_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic               last;
  logic               go;

  mul_abs_conv #(.W(WIDTH)) u_abs_a (
    .val_i (src_a),
    .neg_i (is_signed & src_a[WIDTH-1]),
    .res_o (a_abs)
  );

  mul_abs_conv #(.W(WIDTH)) u_abs_b (
    .val_i (src_b),
    .neg_i (is_signed & src_b[WIDTH-1]),
    .res_o (b_abs)
  );

  mul_abs_conv #(.W(2*WIDTH)) u_fix (
    .val_i ({acc_q, mplier_q}),
    .neg_i (sign_q),
    .res_o (prod_fix)
  );

  // Carry of the WIDTH+1-bit add drops into the shifted accumulator.
  assign addend = mplier_q[0] ? {1'b0, mcand_q} : '0;
  assign sum    = {1'b0, acc_q} + addend;
  assign step   = {sum, mplier_q[WIDTH-1:1]};

`ifdef SEQ_MUL_EARLY_TERM_EN
  logic [WIDTH-1:0] lim;
  logic             skip;

  // Only bit 0 may remain set: do this step and the rest of the shifts at once.
  assign lim    = ~({WIDTH{1'b1}} << count_q);
  assign skip   = ((mplier_q & lim) >> 1) == '0;
  assign last   = skip || (count_q == CW'(1));
  assign prod_d = skip ? (step >> (count_q - CW'(1))) : step;
`else
  assign last   = count_q == CW'(1);
  assign prod_d = step;
`endif

  assign go = start && !flush && ((op == MUL_LOAD) || (op == MUL_ACC));

  assign busy    = busy_q;
  assign mul     = flush ? MUL_NONE : mul_q;
  assign mul_ans = (state_q == S_DONE) ? prod_fix : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= MUL_NONE;
      mul_q    <= MUL_NONE;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          mul_q <= MUL_NONE;
          if (go) begin
            state_q  <= S_CALC;
            busy_q   <= 1'b1;
            op_q     <= op;
            sign_q   <= is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            mcand_q  <= a_abs;
            mplier_q <= b_abs;
            acc_q    <= '0;
            count_q  <= CW'(WIDTH);
          end
        end
        S_CALC: begin
          if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            {acc_q, mplier_q} <= prod_d;
            count_q <= count_q - CW'(1);
            if (last) begin
              state_q <= S_DONE;
              mul_q   <= op_q;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          mul_q   <= MUL_NONE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          mul_q   <= MUL_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier; expected latency follows SEQ_MUL_EARLY_TERM_EN.
// Models a HI/LO register fed by the multiplier commands.
module tb_seq_multiplier;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic        is_signed;
  logic        flush;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [63:0] mul_ans;
  logic [1:0]  mul;

  logic [65:0] exp_q[$];
  logic [63:0] hilo;
  int          n_chk = 0;
  int          n_pass = 0;

  seq_multiplier #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .is_signed (is_signed),
    .flush     (flush),
    .src_a     (src_a),
    .src_b     (src_b),
    .busy      (busy),
    .mul_ans   (mul_ans),
    .mul       (mul)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, got, exp);
  endtask

  function automatic logic [63:0] model(input logic sg,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] x;
    logic [63:0] y;
    x = sg ? {{32{a[31]}}, a} : {32'b0, a};
    y = sg ? {{32{b[31]}}, b} : {32'b0, b};
    return x * y;
  endfunction

  // Edges after the start edge until the command is visible.
  function automatic int exp_lat(input logic sg, input logic [31:0] b);
`ifdef SEQ_MUL_EARLY_TERM_EN
    logic [31:0] m;
    int h;
    m = (sg && b[31]) ? -b : b;
    h = -1;
    for (int i = 0; i < 32; i++) if (m[i]) h = i;
    return (h < 0) ? 1 : h + 1;
`else
    return 32;
`endif
  endfunction

  always @(negedge clk) begin
    if (!reset && mul != MUL_NONE) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cmd", {62'b0, mul}, 64'd0);
      end else begin
        logic [65:0] e;
        e = exp_q.pop_front();
        check("cmd", {62'b0, mul}, {62'b0, e[65:64]});
        check("ans", mul_ans, e[63:0]);
        if (mul == MUL_LOAD) hilo = mul_ans;
        else if (mul == MUL_ACC) hilo = hilo + mul_ans;
      end
    end
  end

  task automatic run_mul(input logic [1:0] op_v, input logic sg,
                         input logic [31:0] a, input logic [31:0] b,
                         input int poke_at);
    int cnt;
    logic busy_ok;
    @(negedge clk);
    start = 1'b1; op = op_v; is_signed = sg; src_a = a; src_b = b;
    exp_q.push_back({op_v, model(sg, a, b)});
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    busy_ok = 1'b1;
    while (mul == MUL_NONE && cnt <= 40) begin
      if (!busy) busy_ok = 1'b0;
      if (cnt == poke_at) begin
        start = 1'b1; src_a = $urandom; src_b = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cnt++;
    end
    if (!busy) busy_ok = 1'b0;
    check("latency", 64'(cnt), 64'(exp_lat(sg, b)));
    check("busy_held", {63'b0, busy_ok}, 64'd1);
    @(posedge clk); #1;
    check("pulse_end", {62'b0, mul}, 64'd0);
    check("idle_after", {63'b0, busy}, 64'd0);
  endtask

  task automatic start_op(input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = MUL_LOAD; is_signed = 1'b0;
    src_a = 32'h1234_5678; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = MUL_NONE; is_signed = 1'b0;
    flush = 1'b0; src_a = '0; src_b = '0; hilo = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_mul", {62'b0, mul}, 64'd0);
    check("rst_ans", mul_ans, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_mul(MUL_LOAD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_mul(MUL_LOAD, 1'b1, 32'hFFFF_FFFE, 32'd3, -1);
    run_mul(MUL_LOAD, 1'b1, 32'h8000_0000, 32'h8000_0000, -1);
    run_mul(MUL_LOAD, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, -1);
    run_mul(MUL_LOAD, 1'b0, 32'd10, 32'd10, -1);
    run_mul(MUL_ACC, 1'b0, 32'd5, 32'd7, -1);
    check("hilo_acc", hilo, 64'd135);
    run_mul(MUL_LOAD, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_0001, 5);
    run_mul(MUL_LOAD, 1'b0, 32'd9, 32'd1, -1);
    run_mul(MUL_LOAD, 1'b0, 32'd9, 32'd0, -1);
    for (int i = 0; i < 6; i++)
      run_mul(($urandom_range(0, 1) != 0) ? MUL_ACC : MUL_LOAD,
              1'($urandom_range(0, 1)), $urandom, $urandom, -1);

    // Invalid op codes and start+flush must not launch.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b1;
      op = (k == 0) ? 2'b00 : (k == 1) ? 2'b11 : MUL_LOAD;
      flush = (k == 2);
      src_a = 32'd3; src_b = 32'd4;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check("no_launch", {63'b0, busy}, 64'd0);
    end

    // Flush mid-calculation.
    start_op(32'hFFFF_FFFF);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {63'b0, busy}, 64'd0);
    repeat (40) @(posedge clk);

    // Flush coinciding with the command cycle.
    start_op(32'hFFFF_FFFF);
    begin
      int w;
      w = 0;
      while (mul == MUL_NONE && w < 40) begin
        @(posedge clk); #1;
        w++;
      end
      check("done_reached", {62'b0, mul}, {62'b0, MUL_LOAD});
      flush = 1'b1;
      #1 check("done_flush", {62'b0, mul}, 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;
    end

    // Asynchronous reset mid-operation.
    start_op(32'hFFFF_FFFF);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_busy", {63'b0, busy}, 64'd0);
    check("mid_rst_mul", {62'b0, mul}, 64'd0);
    check("mid_rst_ans", mul_ans, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1 check("post_rst_busy", {63'b0, busy}, 64'd0);

    repeat (3) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
